// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared cpu constants for instruction field positions and opcodes
package fetch_stage_pkg;
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int FUNC_MSB = 6;
    localparam int FUNC_LSB = 2;
    localparam logic [31:0] NOP_INSN = 32'h0;
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_J     = 5'b00001;
    localparam logic [4:0] OPC_BNE   = 5'b00010;
    localparam logic [4:0] OPC_JAL   = 5'b00011;
    localparam logic [4:0] OPC_JR    = 5'b00100;
    localparam logic [4:0] OPC_BLT   = 5'b00110;
    localparam logic [4:0] OPC_SW    = 5'b00111;
    localparam logic [4:0] OPC_LW    = 5'b01000;
    localparam logic [4:0] OPC_SETX  = 5'b10101;
    localparam logic [4:0] OPC_BEX   = 5'b10110;
endpackage

// File: rtl/fetch_stage_sat_counter.sv
// sat_counter: counter that adds 0..3 per edge and sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W:0] sum;
    assign sum = {1'b0, count} + {{(CNT_W-1){1'b0}}, inc};
    // Add the increment, clamping on carry-out
    always_ff @(posedge clock) begin
        if (reset) count <= '0;
        else count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with 1-entry skid buffer and F/D pipeline register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               redirect_in,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] address_imem,
    input  logic [31:0]        q_imem,
    output logic               fd_valid,
    output logic [PC_W-1:0]    fd_pc,
    output logic [31:0]        fd_insn,
    output logic [4:0]         fd_opcode,
    output logic [4:0]         fd_func,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);
    logic [PC_W-1:0] req_pc, resp_pc, skid_pc;
    logic [31:0]     skid_insn;
    logic            resp_v, skid_v;
    logic [1:0]      fetch_inc, flush_inc;

    assign address_imem = req_pc[IMEM_AW-1:0];
    assign fd_opcode    = fd_insn[OPC_MSB:OPC_LSB];
    assign fd_func      = fd_insn[FUNC_MSB:FUNC_LSB];
    assign fetch_inc    = {1'b0, !redirect_in && !stall_in && (skid_v || resp_v)};
    assign flush_inc    = redirect_in ? {1'b0, fd_valid} + {1'b0, resp_v} + {1'b0, skid_v} : 2'd0;

    // Request/response tracking, skid capture and F/D load; redirect beats stall
    always_ff @(posedge clock) begin
        if (reset) begin
            req_pc   <= RESET_PC;
            resp_v   <= 1'b0;
            skid_v   <= 1'b0;
            fd_valid <= 1'b0;
            fd_pc    <= '0;
            fd_insn  <= NOP_INSN;
        end else if (redirect_in) begin
            req_pc   <= redirect_pc;
            resp_v   <= 1'b0;
            skid_v   <= 1'b0;
            fd_valid <= 1'b0;
            fd_insn  <= NOP_INSN;
        end else if (stall_in) begin
            resp_v <= 1'b0;
            if (resp_v && !skid_v) begin
                skid_pc   <= resp_pc;
                skid_insn <= q_imem;
                skid_v    <= 1'b1;
            end
        end else begin
            req_pc  <= req_pc + PC_W'(1);
            resp_pc <= req_pc;
            resp_v  <= 1'b1;
            if (skid_v) begin
                fd_pc    <= skid_pc;
                fd_insn  <= skid_insn;
                fd_valid <= 1'b1;
                skid_v   <= 1'b0;
            end else begin
                fd_pc    <= resp_pc;
                fd_insn  <= resp_v ? q_imem : NOP_INSN;
                fd_valid <= resp_v;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clock(clock), .reset(reset), .inc(fetch_inc), .count(fetch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock(clock), .reset(reset), .inc(flush_inc), .count(flush_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage flow, stall, redirect, reset and counters
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1, stall_in = 1'b0, redirect_in = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] q_imem = '0;
    logic [11:0] address_imem, address_small;
    logic        fd_valid, fdv_small;
    logic [31:0] fd_pc, fd_insn, pc_small, insn_small;
    logic [4:0]  fd_opcode, fd_func, opc_small, func_small;
    logic [15:0] fetch_count, flush_count;
    logic [3:0]  fetch_small, flush_small;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        q_imem <= (address_imem == 12'h100) ? 32'h2800_0004 : 32'h1000_0000 + {20'h0, address_imem};

    fetch_stage dut (
        .clock(clk), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_pc(redirect_pc), .address_imem(address_imem), .q_imem(q_imem),
        .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_insn(fd_insn), .fd_opcode(fd_opcode),
        .fd_func(fd_func), .fetch_count(fetch_count), .flush_count(flush_count)
    );

    fetch_stage #(.CNT_W(4)) dut_small (
        .clock(clk), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_pc(redirect_pc), .address_imem(address_small), .q_imem(q_imem),
        .fd_valid(fdv_small), .fd_pc(pc_small), .fd_insn(insn_small), .fd_opcode(opc_small),
        .fd_func(func_small), .fetch_count(fetch_small), .flush_count(flush_small)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", {31'b0, fd_valid}, 32'd0);
        chk("rst_pc", fd_pc, 32'd0);
        chk("rst_insn", fd_insn, 32'd0);
        chk("rst_addr", {20'b0, address_imem}, 32'd0);
        chk("rst_fetch", {16'b0, fetch_count}, 32'd0);
        chk("rst_flush", {16'b0, flush_count}, 32'd0);
        reset = 1'b0;
        tick();
        chk("run1_valid", {31'b0, fd_valid}, 32'd0);
        chk("run1_addr", {20'b0, address_imem}, 32'd1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("run_valid", {31'b0, fd_valid}, 32'd1);
            chk("run_pc", fd_pc, i - 2);
            chk("run_insn", fd_insn, 32'h1000_0000 + i - 2);
            chk("run_addr", {20'b0, address_imem}, i);
        end
        chk("run_fetch", {16'b0, fetch_count}, 32'd4);
        tick(); tick();
        chk("pre_stall_pc", fd_pc, 32'd5);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", fd_pc, 32'd5);
            chk("stall_valid", {31'b0, fd_valid}, 32'd1);
            chk("stall_addr", {20'b0, address_imem}, 32'd7);
        end
        chk("stall_fetch", {16'b0, fetch_count}, 32'd6);
        stall_in = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            tick();
            chk("rel_pc", fd_pc, i);
            chk("rel_insn", fd_insn, 32'h1000_0000 + i);
            chk("rel_valid", {31'b0, fd_valid}, 32'd1);
        end
        chk("rel_fetch", {16'b0, fetch_count}, 32'd9);
        redirect_in = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_in = 1'b0;
        chk("redir_valid", {31'b0, fd_valid}, 32'd0);
        chk("redir_insn", fd_insn, 32'd0);
        chk("redir_opc", {27'b0, fd_opcode}, 32'd0);
        chk("redir_flush", {16'b0, flush_count}, 32'd2);
        chk("redir_addr", {20'b0, address_imem}, 32'h40);
        tick();
        chk("redir_gap", {31'b0, fd_valid}, 32'd0);
        tick();
        chk("redir_tgt_valid", {31'b0, fd_valid}, 32'd1);
        chk("redir_tgt_pc", fd_pc, 32'h40);
        chk("redir_tgt_insn", fd_insn, 32'h1000_0040);
        chk("redir_fetch", {16'b0, fetch_count}, 32'd10);
        stall_in = 1'b1;
        tick(); tick();
        chk("skid_hold_pc", fd_pc, 32'h40);
        redirect_in = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_in = 1'b0;
        stall_in = 1'b0;
        chk("rs_valid", {31'b0, fd_valid}, 32'd0);
        chk("rs_flush", {16'b0, flush_count}, 32'd4);
        chk("rs_addr", {20'b0, address_imem}, 32'h100);
        tick();
        chk("rs_gap", {31'b0, fd_valid}, 32'd0);
        tick();
        chk("rs_tgt_pc", fd_pc, 32'h100);
        chk("rs_tgt_insn", fd_insn, 32'h2800_0004);
        chk("rs_opcode", {27'b0, fd_opcode}, 32'h05);
        chk("rs_func", {27'b0, fd_func}, 32'h01);
        tick();
        chk("rs_next_pc", fd_pc, 32'h101);
        chk("rs_fetch", {16'b0, fetch_count}, 32'd12);
        chk("small_fetch12", {28'b0, fetch_small}, 32'd12);
        tick(); tick(); tick();
        chk("small_fetch15", {28'b0, fetch_small}, 32'd15);
        tick();
        chk("main_fetch16", {16'b0, fetch_count}, 32'd16);
        chk("small_sat", {28'b0, fetch_small}, 32'd15);
        chk("small_flush", {28'b0, flush_small}, 32'd4);
        stall_in = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mrst_valid", {31'b0, fd_valid}, 32'd0);
        chk("mrst_insn", fd_insn, 32'd0);
        chk("mrst_addr", {20'b0, address_imem}, 32'd0);
        chk("mrst_fetch", {16'b0, fetch_count}, 32'd0);
        chk("mrst_flush", {16'b0, flush_count}, 32'd0);
        reset = 1'b0;
        stall_in = 1'b0;
        tick();
        chk("mrst_skid_gone", {31'b0, fd_valid}, 32'd0);
        tick();
        chk("mrst_first_valid", {31'b0, fd_valid}, 32'd1);
        chk("mrst_first_pc", fd_pc, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
